// File: rtl/game_countdown_timer.sv
//==============================================================================
// Module  : game_countdown_timer
// Brief   : Game countdown timer driven by a 1 Hz tick, with start, pause,
//           expiry, BCD digits and a low-time warning.
// Revision: 1.0
//==============================================================================
`default_nettype none

module game_countdown_timer #(
   parameter int GAME_TIMER     = 30,
   parameter int WARN_THRESHOLD = 5
) (
   input  logic       clkIn,
   input  logic       reset,
   input  logic       incrementClk,
   input  logic       startGame,
   input  logic       pause,
   output logic       timer_expired,
   output logic [5:0] time_left,
   output logic [3:0] time_tens,
   output logic [3:0] time_ones,
   output logic       warning,
   output logic       counting
);

   localparam logic [5:0] c_game_time  = 6'(GAME_TIMER);
   localparam logic [5:0] c_warn_level = 6'(WARN_THRESHOLD);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COUNTING = 2'd1,
      ST_PAUSED   = 2'd2,
      ST_EXPIRED  = 2'd3
   } state_t;

   state_t r_state;

   logic r_inc_sync1;
   logic r_inc_sync2;
   logic r_inc_sync3;
   logic r_start_d;
   logic w_tick;
   logic w_start_edge;

   // incrementClk is foreign to clkIn: two flops to settle it, a third to find its rising edge.
   // r_start_d resets high so a startGame held through reset release is not seen as an edge.
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         r_inc_sync1 <= 1'b0;
         r_inc_sync2 <= 1'b0;
         r_inc_sync3 <= 1'b0;
         r_start_d   <= 1'b1;
      end else begin
         r_inc_sync1 <= incrementClk;
         r_inc_sync2 <= r_inc_sync1;
         r_inc_sync3 <= r_inc_sync2;
         r_start_d   <= startGame;
      end
   end

   assign w_tick       = r_inc_sync2 & ~r_inc_sync3;
   assign w_start_edge = startGame & ~r_start_d;

   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         time_left     <= c_game_time;
         timer_expired <= 1'b0;
         counting      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               time_left     <= c_game_time;
               timer_expired <= 1'b0;
               if (w_start_edge) begin
                  r_state  <= ST_COUNTING;
                  counting <= 1'b1;
               end else begin
                  counting <= 1'b0;
               end
            end
            ST_COUNTING: begin
               // Pause takes priority so a tick arriving with pause is dropped.
               if (pause) begin
                  r_state  <= ST_PAUSED;
                  counting <= 1'b0;
               end else if (w_tick) begin
                  if (time_left > 6'd1) begin
                     time_left <= time_left - 6'd1;
                  end else begin
                     time_left     <= 6'd0;
                     r_state       <= ST_EXPIRED;
                     timer_expired <= 1'b1;
                     counting      <= 1'b0;
                  end
               end
            end
            ST_PAUSED: begin
               if (!pause) begin
                  r_state  <= ST_COUNTING;
                  counting <= 1'b1;
               end
            end
            ST_EXPIRED: begin
               if (w_start_edge) begin
                  time_left     <= c_game_time;
                  r_state       <= ST_COUNTING;
                  timer_expired <= 1'b0;
                  counting      <= 1'b1;
               end else begin
                  time_left     <= 6'd0;
                  timer_expired <= 1'b1;
                  counting      <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               time_left     <= c_game_time;
               timer_expired <= 1'b0;
               counting      <= 1'b0;
            end
         endcase
      end
   end

   assign time_tens = 4'(time_left / 6'd10);
   assign time_ones = 4'(time_left % 6'd10);

   assign warning = ((r_state == ST_COUNTING) || (r_state == ST_PAUSED)) &&
                    (time_left != 6'd0) && (time_left <= c_warn_level);

endmodule

`default_nettype wire
